// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin arbiter sharing one Wishbone classic peripheral
// port between pCtrls controllers. Define WB_ARB_TIMEOUT_EN for forced ack.
module wb_arbiter #(
    parameter int pCtrls   = 2,
    parameter int pAdrW    = 4,
    parameter int pDatW    = 8,
    parameter int pTimeout = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [pCtrls-1:0]         c_stb,
    input  logic [pCtrls-1:0]         c_we,
    input  logic [pCtrls*pAdrW-1:0]   c_adr,
    input  logic [pCtrls*pDatW-1:0]   c_dat,
    output logic [pCtrls-1:0]         c_ack,
    output logic [pDatW-1:0]          c_dat_r,
    output logic                      p_stb,
    output logic                      p_we,
    output logic [pAdrW-1:0]          p_adr,
    output logic [pDatW-1:0]          p_dat,
    input  logic                      p_ack,
    input  logic [pDatW-1:0]          p_dat_r,
    output logic [$clog2(pCtrls)-1:0] grant,
    output logic                      busy,
    output logic                      timeout
);

    localparam int GW = $clog2(pCtrls);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [GW-1:0] grant_q, grant_d;
    logic [GW-1:0] last_q, last_d;
    logic [GW-1:0] pick;
    logic          found;
    logic          gnt_stb;
    logic          gnt_ack;
    logic          expire;

    assign gnt_stb = c_stb[grant_q];
    assign gnt_ack = p_ack & gnt_stb;
    assign busy    = (state_q == BUSY);

    // Round-robin search starting just after the last served controller.
    always_comb begin
        int            idx;
        logic [GW-1:0] idx_w;
        idx   = 0;
        idx_w = '0;
        pick  = last_q;
        found = 1'b0;
        for (int k = 1; k <= pCtrls; k++) begin
            idx   = (int'(last_q) + k) % pCtrls;
            idx_w = idx[GW-1:0];
            if (!found && c_stb[idx_w]) begin
                found = 1'b1;
                pick  = idx_w;
            end
        end
    end

`ifdef WB_ARB_TIMEOUT_EN
    localparam int CW = (pTimeout > 2) ? $clog2(pTimeout) : 1;
    localparam logic [CW-1:0] TMAX = CW'(pTimeout - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign expire = busy & gnt_stb & ~p_ack & (cnt_q == TMAX);

    // Cycle counter: zero while idle, counts BUSY cycles lacking p_ack.
    always_comb begin
        cnt_d = cnt_q;
        if (!busy)
            cnt_d = '0;
        else if (!p_ack)
            cnt_d = cnt_q + 1'b1;
    end

    // Timeout counter register.
    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
`else
    // No forced termination: the comparison is false for any legal pTimeout.
    assign expire = (pTimeout < 0);
`endif

    // Next-state: arbitrate in IDLE, release on ack, abort or expiry.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (gnt_ack || !gnt_stb || expire) begin
                    last_d  = grant_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbiter state registers; controller 0 has first priority after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= GW'(pCtrls - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Bus steering from the granted controller slice.
    always_comb begin
        p_stb   = busy & gnt_stb & ~expire;
        p_we    = c_we[grant_q];
        p_adr   = c_adr[grant_q*pAdrW +: pAdrW];
        p_dat   = c_dat[grant_q*pDatW +: pDatW];
        c_ack   = '0;
        if (busy && (gnt_ack || expire))
            c_ack = pCtrls'(1) << grant_q;
        c_dat_r = expire ? '1 : p_dat_r;
        timeout = expire;
        grant   = grant_q;
    end

endmodule

// File: doc/wb_arbiter.md
Name: wb_arbiter

Overview:
Round-robin arbiter that shares one Wishbone peripheral port between pCtrls Wishbone controllers (e.g. SPI bridge, UART bridge, debug core).
- Sits between the controllers and the peripheral interconnect.
- Grants one controller at a time and holds the grant until the transfer is acknowledged or aborted.
- Exports the current grant and bus activity for the debug LED monitor.

Parameters:
pCtrls, 2, number of requesting controllers (2..8).
pAdrW, 4, address width.
pDatW, 8, data width.
pTimeout, 16, cycles allowed for p_ack before a forced termination (used only with WB_ARB_TIMEOUT_EN).

Ports:
clk  in  1  clock.
rst  in  1  reset; synchronous, active-high.
c_stb  in  pCtrls  strobe per controller.
c_we  in  pCtrls  write enable per controller.
c_adr  in  pCtrls*pAdrW  address; controller i occupies slice [i*pAdrW +: pAdrW].
c_dat  in  pCtrls*pDatW  write data, sliced as for c_adr.
c_ack  out  pCtrls  acknowledge per controller.
c_dat_r  out  pDatW  read data, shared by all controllers.
p_stb  out  1  strobe to the peripheral.
p_we  out  1  write enable to the peripheral.
p_adr  out  pAdrW  address to the peripheral.
p_dat  out  pDatW  write data to the peripheral.
p_ack  in  1  acknowledge from the peripheral.
p_dat_r  in  pDatW  read data from the peripheral.
grant  out  $clog2(pCtrls)  index of the current or most recently granted controller.
busy  out  1  high while in BUSY.
timeout  out  1  one-cycle pulse on forced termination; tied 0 without the macro.

Behaviour:
Protocol:
- Wishbone classic handshake: a controller raises stb and holds stb/we/adr/dat stable until it sees ack.
- ack is a single-cycle pulse.
- The controller must drop stb, or present a new request, in the cycle after ack.

States: IDLE, BUSY.

Reset:
- state=IDLE, last=pCtrls-1 (controller 0 has first priority), grant=0.
- All outputs 0: p_stb, c_ack, busy, timeout.
- A reset during BUSY aborts the transfer immediately with no ack to any controller.

IDLE:
- If any c_stb is high, grant the first requester searching from last+1, wrapping modulo pCtrls.
- Register the grant and go to BUSY.
- Arbitration costs exactly one cycle; p_stb first rises in the cycle after the request is seen.
- If no c_stb is high, stay in IDLE.

BUSY:
- p_stb = c_stb[grant]. p_we, p_adr and p_dat are driven combinationally from the granted slice.
- c_ack = p_ack on bit [grant] only; all other bits 0.
- c_dat_r = p_dat_r.
- On p_ack && c_stb[grant]: record last=grant and go to IDLE.
- If c_stb[grant] drops without p_ack (abort): go to IDLE, drive no ack, update last.

Simultaneous events:
- Requests from other controllers during BUSY are ignored; those controllers stall with stb high.
- A new request raised in the same cycle as p_ack is arbitrated in the following IDLE cycle.
- A controller re-requesting right after its own ack loses to any other pending requester.

Fairness:
- With all pCtrls controllers requesting continuously, grants rotate 0,1,...,pCtrls-1,0,...
- Each transfer costs at least 2 cycles (arbitration plus one BUSY cycle).

Outputs:
- grant holds its value while in IDLE.
- In IDLE: p_stb=0 and c_ack=0. p_we, p_adr and p_dat are don't-care but driven from the granted slice.

Optional Feature:
Macro: WB_ARB_TIMEOUT_EN.

With the macro defined:
- A counter is cleared on entry to BUSY and increments on each BUSY cycle without p_ack.
- When the counter reaches pTimeout-1 without p_ack, the arbiter asserts c_ack[grant] for one cycle with c_dat_r = all ones.
- In that same cycle it forces p_stb=0, pulses timeout, and returns to IDLE.
- A p_ack arriving in the same cycle as expiry takes precedence: normal ack, no timeout pulse.

Without the macro:
- No counter is built, timeout is tied 0, and BUSY waits indefinitely for p_ack.

Test Plan:
1. Reset, then c_stb=2'b01, adr=4'h3, we=0; peripheral acks 3 cycles after p_stb with p_dat_r=8'hA5 -> p_stb rises 1 cycle after the request, p_adr=4'h3, c_ack=2'b01 for exactly 1 cycle, c_dat_r=8'hA5, grant=0.
2. c_stb=2'b11 held continuously, every transfer acked after 1 cycle -> grant sequence 0,1,0,1; c_ack never has 2 bits set; each transfer takes 2 cycles.
3. Controller 1 writes adr=4'h7 dat=8'h3C while controller 0 raises stb mid-transfer -> p_adr/p_dat stay 4'h7/8'h3C until p_ack; controller 0 is granted next.
4. Granted controller drops c_stb before p_ack -> p_stb falls in the same cycle, no c_ack, busy=0 next cycle.
5. Assert rst during BUSY -> next cycle p_stb=0, c_ack=0, busy=0; first grant after reset goes to controller 0.
6. With WB_ARB_TIMEOUT_EN and pTimeout=16, the peripheral never acks -> c_ack[grant] and timeout pulse together at the 16th BUSY cycle with c_dat_r=8'hFF, then IDLE; without the macro, busy stays high indefinitely.
